sram_access_arbiter: RTL and testbench
======================================

Name: sram_access_arbiter

Overview:
- Shares the single external SRAM port (18-bit address, 16-bit data, active-low write enable) among three requesters.
  - Client 0: UART loader.
  - Client 1: decoder datapath.
  - Client 2: VGA/readback unit.
- Round-robin grant with a hold limit; registered SRAM drive; returns read data tagged with a per-client valid.
- Sits between the client modules and the SRAM controller at top level.

Parameters:
- MAX_HOLD, 256: max granted cycles while another client is requesting; range 1..65535.
- READ_LATENCY, 2: cycles from SRAM address presented to SRAM_read_data valid.

Ports:
- Clock  in  1  system clock
- Resetn  in  1  reset
- Initialize  in  1  synchronous clear, same effect as reset
- Req  in  3  per-client request; held high for a burst
- Grant  out  3  one-hot grant, registered
- Access  in  3  per-client access strobe; honoured only when Grant[k]=1
- Client_address  in  54  client k address at [18k+17:18k]
- Client_write_data  in  48  client k data at [16k+15:16k]
- Client_we_n  in  3  client k access type: 0=write, 1=read
- SRAM_read_data  in  16  data from SRAM controller
- SRAM_address  out  18  registered
- SRAM_write_data  out  16  registered
- SRAM_we_n  out  1  registered
- Read_data  out  16  combinational pass-through of SRAM_read_data
- Read_data_valid  out  3  one-hot per-client read return
- Busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset and clocking: Resetn is asynchronous, active-low; clock is Clock; all state is updated on posedge Clock.
- Reset values:
  - Grant=0, SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1.
  - Read_data_valid=0, Busy=0.
  - State=S_ARB_IDLE, last_owner=2 (client 0 wins first), hold_count=0, tag pipeline cleared.
- Initialize=1 applies the reset values synchronously and overrides all other activity, including mid-burst: pending read tags are discarded and no valids are issued.
- S_ARB_IDLE:
  - If any Req is high, pick the first requester scanning last_owner+1, +2, +3 (mod 3).
  - Next edge: Grant[winner]=1, owner=winner, last_owner=winner, hold_count=0, go to S_ARB_OWN.
  - Grant latency from Req is 1 cycle in IDLE.
- S_ARB_OWN:
  - Each cycle with Access[owner]=1, the next edge loads SRAM_address, SRAM_write_data and SRAM_we_n from owner's inputs.
    - If Client_we_n=0, SRAM_we_n is low for exactly that one cycle.
    - If Client_we_n=1, SRAM_we_n=1 and the owner tag is pushed into the read pipeline.
  - Cycle with no access: SRAM_we_n=1; SRAM_address and SRAM_write_data hold their values.
  - Access from non-owners is ignored.
  - hold_count increments every cycle, saturating.
  - Release occurs when Req[owner]=0, or when hold_count>=MAX_HOLD-1 and any other Req is high. On release:
    - Grant clears on that edge; go to S_ARB_DRAIN.
    - An Access sampled in the release cycle is still honoured.
- S_ARB_DRAIN:
  - SRAM_we_n=1; no new accesses.
  - Stay until the read pipeline is empty, then go to IDLE.
  - If the pipeline is already empty, DRAIN lasts 1 cycle.
- Read return:
  - An access sampled at edge t drives SRAM in cycle t+1.
  - Read_data_valid[owner] is high in cycle t+1+READ_LATENCY, for one cycle per read.
  - Read reads may issue back-to-back, one per cycle; the pipeline depth is READ_LATENCY+1 entries.
- Invariants:
  - Grant and Read_data_valid are each at most one-hot.
  - Grant is never high outside S_ARB_OWN.
- Fairness: worst-case wait for a requesting client is 2*(MAX_HOLD+READ_LATENCY+3) cycles.

Decomposition:
- Add to define_state.h:
  - SRAM_arb_state_type with S_ARB_IDLE, S_ARB_OWN, S_ARB_DRAIN.
  - Client index constants: CLIENT_UART=0, CLIENT_DEC=1, CLIENT_VGA=2.
- Sub-module sram_read_tag_pipe:
  - Parameterised shift register of (valid, 2-bit tag) of depth READ_LATENCY+1.
  - Outputs the decoded one-hot valid and an empty flag.

Test Plan:
- Reset, then Req=3'b001, client 0 issues 4 writes to 0x00010..0x00013 with data 0xA5A0..0xA5A3 → Grant=001 one cycle after Req; SRAM_we_n low exactly 4 cycles; addresses and data appear in order, each one cycle after its Access.
- Client 1 reads 0x00020..0x00022 back-to-back, with the SRAM model returning the address low bits → Read_data_valid=010 on 3 consecutive cycles starting 1+READ_LATENCY cycles after the first Access; Read_data=0x0020, 0x0021, 0x0022.
- All three Req held continuously, MAX_HOLD=4 → grants rotate 0,1,2,0; each grant lasts exactly 4 cycles; DRAIN occurs between grants; no overlap.
- Client 2 releases Req in the same cycle as its last read Access → the read is honoured, Read_data_valid=100 arrives during DRAIN, and IDLE is not entered before it.
- Non-owner Access (client 1 strobing while client 0 owns) → SRAM outputs follow only client 0; no valid is issued for client 1.
- Initialize pulsed while reads are in flight → Grant=0 next cycle, no Read_data_valid afterwards, state IDLE, next arbitration grants client 0 first.

Source files
------------

// File: rtl/sram_access_arbiter_pkg.sv
// Shared types and constants for the three-client SRAM arbiter: FSM states,
// client indices and the round-robin pick helper.
package sram_access_arbiter_pkg;

  typedef enum logic [1:0] {
    S_ARB_IDLE  = 2'd0,
    S_ARB_OWN   = 2'd1,
    S_ARB_DRAIN = 2'd2
  } sram_arb_state_type;

  localparam int NUM_CLIENTS = 3;
  localparam int ADDR_W      = 18;
  localparam int DATA_W      = 16;
  localparam int HOLD_W      = 16;

  localparam logic [1:0] CLIENT_UART = 2'd0;
  localparam logic [1:0] CLIENT_DEC  = 2'd1;
  localparam logic [1:0] CLIENT_VGA  = 2'd2;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } arb_pick_t;

  // First requester after last_owner, wrapping through all three so that a
  // lone repeat requester can win again.
  function automatic arb_pick_t rr_pick(input logic [1:0] last_owner,
                                        input logic [NUM_CLIENTS-1:0] req);
    arb_pick_t  pick;
    logic [1:0] cand;
    pick.found = 1'b0;
    pick.idx   = CLIENT_UART;
    cand       = last_owner;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      case (cand)
        CLIENT_UART: cand = CLIENT_DEC;
        CLIENT_DEC:  cand = CLIENT_VGA;
        default:     cand = CLIENT_UART;
      endcase
      if (!pick.found && req[cand]) begin
        pick.found = 1'b1;
        pick.idx   = cand;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sram_read_tag_pipe.sv
// Shift register of (valid, client tag) that follows each SRAM read until its
// data returns; the last stage drives the per-client read valid.
module sram_read_tag_pipe
  import sram_access_arbiter_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic                   clear,
  input  logic                   push,
  input  logic [1:0]             push_tag,
  output logic [NUM_CLIENTS-1:0] valid_onehot,
  output logic                   empty
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [1:0]       tag_q [DEPTH];
  logic [1:0]       tag_d [DEPTH];

  always_comb begin
    vld_d[0] = push;
    tag_d[0] = push_tag;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
    if (clear) begin
      vld_d = '0;
      for (int i = 0; i < DEPTH; i++) tag_d[i] = '0;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= tag_d[i];
    end
  end

  genvar gi;
  for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_decode
    assign valid_onehot[gi] = vld_q[DEPTH-1] && (tag_q[DEPTH-1] == 2'(gi));
  end

  assign empty = ~|vld_q;

endmodule

// File: rtl/sram_access_arbiter.sv
// Round-robin owner of the external SRAM port for the UART loader, decoder and
// VGA readback clients, with a hold limit and tagged read returns.
module sram_access_arbiter
  import sram_access_arbiter_pkg::*;
#(
  parameter int MAX_HOLD     = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic                          Clock,
  input  logic                          Resetn,
  input  logic                          Initialize,
  input  logic [NUM_CLIENTS-1:0]        Req,
  output logic [NUM_CLIENTS-1:0]        Grant,
  input  logic [NUM_CLIENTS-1:0]        Access,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] Client_address,
  input  logic [NUM_CLIENTS*DATA_W-1:0] Client_write_data,
  input  logic [NUM_CLIENTS-1:0]        Client_we_n,
  input  logic [DATA_W-1:0]             SRAM_read_data,
  output logic [ADDR_W-1:0]             SRAM_address,
  output logic [DATA_W-1:0]             SRAM_write_data,
  output logic                          SRAM_we_n,
  output logic [DATA_W-1:0]             Read_data,
  output logic [NUM_CLIENTS-1:0]        Read_data_valid,
  output logic                          Busy
);

  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT   = '1;

  sram_arb_state_type     state_q, state_d;
  logic [1:0]             owner_q, owner_d;
  logic [1:0]             last_owner_q, last_owner_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [NUM_CLIENTS-1:0] grant_q, grant_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   we_n_q, we_n_d;
  logic                   rd_push, pipe_clear, pipe_empty, other_req;
  arb_pick_t              pick;

  logic [ADDR_W-1:0] cl_addr  [NUM_CLIENTS];
  logic [DATA_W-1:0] cl_wdata [NUM_CLIENTS];

  genvar gi;
  for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
    assign cl_addr[gi]  = Client_address[ADDR_W*gi +: ADDR_W];
    assign cl_wdata[gi] = Client_write_data[DATA_W*gi +: DATA_W];
  end

  always_comb begin
    pick         = rr_pick(last_owner_q, Req);
    other_req    = |(Req & ~grant_q);
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    hold_d       = hold_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_n_d       = 1'b1;
    rd_push      = 1'b0;
    pipe_clear   = 1'b0;

    case (state_q)
      S_ARB_IDLE: begin
        if (pick.found) begin
          state_d      = S_ARB_OWN;
          owner_d      = pick.idx;
          last_owner_d = pick.idx;
          hold_d       = '0;
          grant_d      = 3'b001 << pick.idx;
        end
      end
      S_ARB_OWN: begin
        // The access sampled on the release edge still goes out.
        if (Access[owner_q]) begin
          addr_d  = cl_addr[owner_q];
          wdata_d = cl_wdata[owner_q];
          we_n_d  = Client_we_n[owner_q];
          rd_push = Client_we_n[owner_q];
        end
        if (hold_q != HOLD_SAT) hold_d = hold_q + 1'b1;
        if (!Req[owner_q] || (hold_q >= HOLD_LIMIT && other_req)) begin
          state_d = S_ARB_DRAIN;
          grant_d = '0;
        end
      end
      S_ARB_DRAIN: begin
        if (pipe_empty) state_d = S_ARB_IDLE;
      end
      default: state_d = S_ARB_IDLE;
    endcase

    if (Initialize) begin
      state_d      = S_ARB_IDLE;
      owner_d      = CLIENT_UART;
      last_owner_d = CLIENT_VGA;
      hold_d       = '0;
      grant_d      = '0;
      addr_d       = '0;
      wdata_d      = '0;
      we_n_d       = 1'b1;
      rd_push      = 1'b0;
      pipe_clear   = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= S_ARB_IDLE;
      owner_q      <= CLIENT_UART;
      last_owner_q <= CLIENT_VGA;
      hold_q       <= '0;
      grant_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_n_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      hold_q       <= hold_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_n_q       <= we_n_d;
    end
  end

  sram_read_tag_pipe #(
    .DEPTH(READ_LATENCY + 1)
  ) u_tag_pipe (
    .Clock        (Clock),
    .Resetn       (Resetn),
    .clear        (pipe_clear),
    .push         (rd_push),
    .push_tag     (owner_q),
    .valid_onehot (Read_data_valid),
    .empty        (pipe_empty)
  );

  assign Grant           = grant_q;
  assign SRAM_address    = addr_q;
  assign SRAM_write_data = wdata_q;
  assign SRAM_we_n       = we_n_q;
  assign Read_data       = SRAM_read_data;
  assign Busy            = (state_q != S_ARB_IDLE);

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Randomised and directed bench for sram_access_arbiter, checked against a
// transaction-level model that schedules read returns by edge number.
module tb_sram_access_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int RL       = 2;
  localparam int P_IDLE = 0, P_OWN = 1, P_DRAIN = 2;

  logic        Clock = 1'b0, Resetn = 1'b0, Initialize = 1'b0;
  logic [2:0]  Req = '0, Access = '0, Client_we_n = '1;
  logic [53:0] Client_address = '0;
  logic [47:0] Client_write_data = '0;
  logic [15:0] SRAM_read_data = '0;
  logic [2:0]  Grant, Read_data_valid;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data, Read_data;
  logic        SRAM_we_n, Busy;

  sram_access_arbiter #(.MAX_HOLD(MAX_HOLD), .READ_LATENCY(RL)) dut (
    .Clock(Clock), .Resetn(Resetn), .Initialize(Initialize),
    .Req(Req), .Grant(Grant), .Access(Access),
    .Client_address(Client_address), .Client_write_data(Client_write_data),
    .Client_we_n(Client_we_n), .SRAM_read_data(SRAM_read_data),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n(SRAM_we_n), .Read_data(Read_data),
    .Read_data_valid(Read_data_valid), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: phase/owner bookkeeping plus a list of scheduled returns.
  typedef struct { int due; int client; logic [15:0] data; } rd_t;
  rd_t         m_rd[$];
  int          m_phase = P_IDLE, m_owner = 0, m_last = 2, m_age = 0, edge_n = 0;
  logic [17:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic        m_we_n = 1'b1;

  // Directed-sequence observations.
  int          we_low_cnt, vcnt[3], first_vld1, cur_len;
  bit          vld_in_drain;
  logic [15:0] rd1_log[$];
  int          grant_own_log[$], grant_len_log[$];
  logic [2:0]  prev_grant = '0;

  function automatic bit pending(input int from);
    bit p = 1'b0;
    foreach (m_rd[i]) if (m_rd[i].due >= from) p = 1'b1;
    return p;
  endfunction

  task automatic model_step();
    bit others, rel, won;
    edge_n++;
    if (Initialize) begin
      m_phase = P_IDLE; m_last = 2; m_age = 0; m_owner = 0;
      m_addr = '0; m_wdata = '0; m_we_n = 1'b1; m_rd.delete();
      return;
    end
    m_we_n = 1'b1;
    case (m_phase)
      P_IDLE: begin
        won = 1'b0;
        for (int k = 1; k <= 3; k++) begin
          if (!won && Req[(m_last + k) % 3]) begin
            won = 1'b1; m_owner = (m_last + k) % 3; m_last = m_owner;
            m_age = 0; m_phase = P_OWN;
          end
        end
      end
      P_OWN: begin
        others = |(Req & ~(3'b001 << m_owner));
        rel = !Req[m_owner] || (m_age >= MAX_HOLD - 1 && others);
        if (Access[m_owner]) begin
          m_addr  = Client_address[18*m_owner +: 18];
          m_wdata = Client_write_data[16*m_owner +: 16];
          m_we_n  = Client_we_n[m_owner];
          if (m_we_n) m_rd.push_back('{due: edge_n + RL, client: m_owner, data: m_addr[15:0]});
          $display("edge %0d client %0d %s addr=%05h wdata=%04h", edge_n, m_owner,
                   m_we_n ? "RD" : "WR", m_addr, m_wdata);
        end
        if (m_age < 65535) m_age++;
        if (rel) m_phase = P_DRAIN;
      end
      default: if (!pending(edge_n - 1)) m_phase = P_IDLE;
    endcase
  endtask

  task automatic tick();
    logic [2:0]  exp_vld;
    logic [15:0] exp_rd;
    @(posedge Clock);
    model_step();
    exp_vld = '0;
    exp_rd  = 16'($urandom);
    foreach (m_rd[i]) if (m_rd[i].due == edge_n) begin
      exp_vld = 3'(3'b001 << m_rd[i].client);
      exp_rd  = m_rd[i].data;
    end
    SRAM_read_data = exp_rd;
    #1;
    chk("grant", Grant, (m_phase == P_OWN) ? 3'(3'b001 << m_owner) : 3'b000);
    chk("busy", Busy, m_phase != P_IDLE);
    chk("sram_addr", SRAM_address, m_addr);
    chk("sram_wdata", SRAM_write_data, m_wdata);
    chk("sram_we_n", SRAM_we_n, m_we_n);
    chk("rd_valid", Read_data_valid, exp_vld);
    if (exp_vld != 0) begin
      chk("rd_data", Read_data, exp_rd);
      $display("edge %0d client %0d RET data=%04h", edge_n, $clog2(exp_vld), Read_data);
    end
    if (Read_data_valid != 0) chk("busy_on_valid", Busy, 1);
    if (SRAM_we_n === 1'b0) we_low_cnt++;
    for (int k = 0; k < 3; k++) if (Read_data_valid[k] === 1'b1) vcnt[k]++;
    if (Read_data_valid[1] === 1'b1) begin
      rd1_log.push_back(Read_data);
      if (first_vld1 < 0) first_vld1 = edge_n;
    end
    if (Read_data_valid === 3'b100 && Grant === 3'b000 && Busy === 1'b1) vld_in_drain = 1'b1;
    if (Grant != 0 && prev_grant == 0) begin
      grant_own_log.push_back(Grant[0] ? 0 : (Grant[1] ? 1 : 2));
      cur_len = 0;
    end
    if (Grant != 0) cur_len++;
    if (Grant == 0 && prev_grant != 0) grant_len_log.push_back(cur_len);
    prev_grant = Grant;
    for (int i = m_rd.size() - 1; i >= 0; i--) if (m_rd[i].due < edge_n) m_rd.delete(i);
  endtask

  task automatic set_client(input int c, input logic [17:0] a, input logic [15:0] d,
                            input logic wn);
    Client_address[18*c +: 18]    = a;
    Client_write_data[16*c +: 16] = d;
    Client_we_n[c]                = wn;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (Busy !== 1'b0 && n < 20) begin tick(); n++; end
    chk(tag, Busy, 0);
  endtask

  task automatic clear_obs();
    we_low_cnt = 0; vcnt = '{0, 0, 0}; first_vld1 = -1; vld_in_drain = 1'b0;
    rd1_log.delete(); grant_own_log.delete(); grant_len_log.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc_edge;
    logic [2:0] orders [4];
    orders = '{3'd0, 3'd1, 3'd2, 3'd0};
    clear_obs();

    // Reset: requests and strobes must be ignored.
    Req = 3'b111; Access = 3'b111;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_grant", Grant, 0);      chk("rst_addr", SRAM_address, 0);
    chk("rst_wdata", SRAM_write_data, 0); chk("rst_we_n", SRAM_we_n, 1);
    chk("rst_valid", Read_data_valid, 0); chk("rst_busy", Busy, 0);
    Resetn = 1'b1; Req = '0; Access = '0;

    // Client 0: four writes.
    Req = 3'b001; tick();
    chk("grant_latency", Grant, 3'b001);
    for (int i = 0; i < 4; i++) begin
      Access = 3'b001; set_client(0, 18'h10 + 18'(i), 16'hA5A0 + 16'(i), 1'b0); tick();
    end
    Access = '0; Req = '0;
    wait_idle("idle_after_writes");
    chk("we_low_cycles", we_low_cnt, 4);

    // Client 1: three back-to-back reads.
    clear_obs();
    Req = 3'b010; tick();
    for (int i = 0; i < 3; i++) begin
      Access = 3'b010; set_client(1, 18'h20 + 18'(i), 16'h0, 1'b1); tick();
      if (i == 0) acc_edge = edge_n;
    end
    Access = '0; Req = '0;
    wait_idle("idle_after_reads");
    chk("rd_count_c1", vcnt[1], 3);
    chk("rd_latency", first_vld1 - acc_edge, RL);
    for (int i = 0; i < 3; i++) chk("rd_data_c1", rd1_log[i], 16'h20 + 16'(i));

    // All clients requesting: rotation from a fresh start.
    Initialize = 1'b1; tick(); Initialize = 1'b0;
    clear_obs();
    Req = 3'b111;
    repeat (28) tick();
    Req = '0;
    wait_idle("idle_after_rotation");
    chk("grant_count", grant_own_log.size() >= 4, 1);
    for (int i = 0; i < 4 && i < grant_own_log.size(); i++) begin
      chk("grant_order", grant_own_log[i], orders[i]);
      chk("grant_len", grant_len_log[i], MAX_HOLD);
    end

    // Client 2 drops Req on its last read.
    clear_obs();
    Req = 3'b100; tick();
    Access = 3'b100; set_client(2, 18'h30, 16'h0, 1'b1); tick();
    set_client(2, 18'h31, 16'h0, 1'b1); Req = '0; tick();
    Access = '0;
    wait_idle("idle_after_c2");
    chk("rd_count_c2", vcnt[2], 2);
    chk("valid_in_drain", vld_in_drain, 1);

    // Non-owner strobes while client 0 owns.
    clear_obs();
    Req = 3'b001; tick();
    Access = 3'b011; set_client(0, 18'h40, 16'h1234, 1'b0); set_client(1, 18'h3FFFF, 16'hFFFF, 1'b1);
    tick();
    chk("nonowner_addr", SRAM_address, 18'h40);
    tick();
    Access = '0; Req = '0;
    wait_idle("idle_after_nonowner");
    chk("nonowner_valid", vcnt[1], 0);

    // Initialize with reads in flight.
    Req = 3'b010; tick();
    Access = 3'b010; set_client(1, 18'h50, 16'h0, 1'b1); tick();
    set_client(1, 18'h51, 16'h0, 1'b1); tick();
    Access = '0; Initialize = 1'b1; tick();
    Initialize = 1'b0; Req = '0;
    clear_obs();
    chk("init_grant", Grant, 0);
    repeat (6) tick();
    chk("init_no_valid", vcnt[0] + vcnt[1] + vcnt[2], 0);
    chk("init_idle", Busy, 0);
    Req = 3'b111; tick();
    chk("init_first_grant", Grant, 3'b001);
    Req = '0;
    wait_idle("idle_after_init");

    // Randomised traffic.
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < 3; k++) if ($urandom_range(7) == 0) Req[k] = ~Req[k];
      Access            = 3'($urandom);
      Client_we_n       = 3'($urandom);
      Client_address    = 54'({$urandom(), $urandom()});
      Client_write_data = 48'({$urandom(), $urandom()});
      Initialize        = ($urandom_range(199) == 0);
      tick();
    end
    Initialize = 1'b0; Req = '0; Access = '0;
    wait_idle("idle_after_random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
